src_sel_arb: RTL and testbench

Round-robin source arbiter and output register that feeds the five-input select mux stage. Up to five requesters present valid/data; the block picks one per cycle with fair rotation, captures its data in an output register, and drives the one-hot select that the downstream mux consumes. A ready/valid handshake on both sides provides backpressure, and a transfer counter supports debug.

---
 rtl/src_sel_arb_if.sv | 27 ++
 rtl/src_sel_arb.sv | 88 ++++++++
 tb/tb_src_sel_arb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/src_sel_arb_if.sv
// Request/output bundle between the five requesters, the round-robin source
// arbiter and the downstream select mux stage.
interface src_sel_arb_if #(
    parameter int NUM_SRC = 5,
    parameter int DW      = 16
);
    logic [NUM_SRC-1:0]    req_vld;
    logic [NUM_SRC*DW-1:0] req_data;
    logic [NUM_SRC-1:0]    req_rdy;
    logic                  out_vld;
    logic [DW-1:0]         out_data;
    logic                  out_rdy;
    logic [NUM_SRC-1:0]    sel_onehot;
    logic [15:0]           gnt_cnt;

    // Requester/consumer side.
    modport master (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data, sel_onehot, gnt_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data, sel_onehot, gnt_cnt
    );
endinterface

// File: rtl/src_sel_arb.sv
// Round-robin source arbiter with a registered output stage that drives the
// one-hot select for the downstream mux, plus a wrapping transfer counter.
module src_sel_arb #(
    parameter int NUM_SRC = 5,
    parameter int DW      = 16
) (
    input  logic         mclk,
    input  logic         mreset_n,
    src_sel_arb_if.slave bus
);
    localparam logic [3:0] NS_W     = 4'(NUM_SRC);
    localparam logic [2:0] PTR_LAST = 3'(NUM_SRC - 1);

    logic [2:0]         ptr;
    logic               out_vld_q;
    logic [DW-1:0]      out_data_q;
    logic [NUM_SRC-1:0] sel_q;
    logic [15:0]        gnt_cnt_q;

    logic               load_en;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         next_ptr;
    logic [3:0]         scan_sum;
    logic [DW-1:0]      win_data;
    logic [NUM_SRC-1:0] win_onehot;

    assign load_en = !out_vld_q || bus.out_rdy;

    // Scan from ptr upward with an explicit wrap; the first valid source wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // NOTE: blocking assignments here; scan_sum is a running temporary.
            scan_sum = {1'b0, ptr} + 4'(k);
            if (scan_sum >= NS_W) scan_sum = scan_sum - NS_W;
            if (!win_found && bus.req_vld[scan_sum[2:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[2:0];
            end
        end
    end

    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == 3'(i)) begin
                win_data      = bus.req_data[i*DW +: DW];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr    = (win_idx == PTR_LAST) ? 3'd0 : win_idx + 3'd1;
    assign bus.req_rdy = (load_en && win_found) ? win_onehot : '0;

    // NOTE: non-blocking assignments for all state; every register is reset since there is no storage array.
    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            ptr        <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            sel_q      <= '0;
            gnt_cnt_q  <= '0;
        end else if (load_en) begin
            if (win_found) begin
                out_data_q <= win_data;
                sel_q      <= win_onehot;
                out_vld_q  <= 1'b1;
                ptr        <= next_ptr;
                gnt_cnt_q  <= gnt_cnt_q + 16'd1;
            end else begin
                // Empty or draining with nobody asking: go empty, keep last data.
                out_vld_q <= 1'b0;
                sel_q     <= '0;
            end
        end
    end

    assign bus.out_vld    = out_vld_q;
    assign bus.out_data   = out_data_q;
    assign bus.sel_onehot = sel_q;
    assign bus.gnt_cnt    = gnt_cnt_q;
endmodule

// File: tb/tb_src_sel_arb.sv
// Randomized and directed bench for src_sel_arb: a behavioural model predicts
// each grant, and a separate monitor checks items as they leave the output.
module tb_src_sel_arb;
    localparam int NS = 5;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NS-1:0] sel;
    } item_t;

    logic mclk = 1'b0;
    logic mreset_n = 1'b0;

    src_sel_arb_if #(.NUM_SRC(NS), .DW(DW)) bus ();

    src_sel_arb #(.NUM_SRC(NS), .DW(DW)) dut (
        .mclk     (mclk),
        .mreset_n (mreset_n),
        .bus      (bus.slave)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int            m_ptr  = 0;
    logic          m_full = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [NS-1:0] m_sel  = '0;
    int            m_cnt  = 0;
    logic [DW-1:0] src_data [NS];
    logic [NS-1:0] cur_v = '0;
    logic          cur_r = 1'b0;
    item_t         sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_winner(input logic [NS-1:0] v);
        for (int k = 0; k < NS; k++) begin
            int i = (m_ptr + k) % NS;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] expected_rdy(input logic [NS-1:0] v, input logic r);
        int w = find_winner(v);
        logic [NS-1:0] e = '0;
        if ((!m_full || r) && w >= 0) e[w] = 1'b1;
        return e;
    endfunction

    task automatic drive(input logic [NS-1:0] v, input logic r);
        cur_v = v;
        cur_r = r;
        bus.req_vld = v;
        bus.out_rdy = r;
        for (int i = 0; i < NS; i++) bus.req_data[i*DW +: DW] = src_data[i];
    endtask

    // One cycle: drive at negedge, check outputs against the model, then
    // advance the model to what the following rising edge must produce.
    task automatic step(input logic [NS-1:0] v, input logic r,
                        output logic [NS-1:0] rdy_seen, output logic [NS-1:0] acc);
        int w;
        item_t it;
        @(negedge mclk);
        drive(v, r);
        #1;
        acc      = expected_rdy(v, r);
        rdy_seen = bus.req_rdy;
        check("req_rdy",    32'(bus.req_rdy),    32'(acc));
        check("out_vld",    32'(bus.out_vld),    32'(m_full));
        check("sel_onehot", 32'(bus.sel_onehot), 32'(m_sel));
        check("out_data",   32'(bus.out_data),   32'(m_data));
        check("gnt_cnt",    32'(bus.gnt_cnt),    32'(m_cnt));
        if (!m_full || r) begin
            w = find_winner(v);
            if (w >= 0) begin
                m_data  = src_data[w];
                m_sel   = NS'(1 << w);
                m_full  = 1'b1;
                m_ptr   = (w + 1) % NS;
                m_cnt   = (m_cnt + 1) % 65536;
                it.data = m_data;
                it.sel  = m_sel;
                sb_q.push_back(it);
            end else begin
                m_full = 1'b0;
                m_sel  = '0;
            end
        end
    endtask

    task automatic apply_reset(input bit rand_inputs, input int offset);
        @(negedge mclk);
        #offset;
        if (rand_inputs) begin
            for (int i = 0; i < NS; i++) src_data[i] = 16'($urandom);
            drive(NS'($urandom), 1'($urandom));
        end
        mreset_n = 1'b0;
        m_ptr = 0; m_full = 1'b0; m_data = '0; m_sel = '0; m_cnt = 0;
        sb_q.delete();
        #1;
        check("rst_out_vld",  32'(bus.out_vld),    32'd0);
        check("rst_sel",      32'(bus.sel_onehot), 32'd0);
        check("rst_out_data", 32'(bus.out_data),   32'd0);
        check("rst_gnt_cnt",  32'(bus.gnt_cnt),    32'd0);
        check("rst_req_rdy",  32'(bus.req_rdy),    32'(expected_rdy(cur_v, cur_r)));
        repeat (2) @(negedge mclk);
        drive('0, 1'b0);
        mreset_n = 1'b1;
    endtask

    // Monitor: an item leaves on every edge where out_vld and out_rdy are both high.
    initial begin
        item_t exp_item;
        forever begin
            @(negedge mclk);
            #2;
            if (mreset_n && bus.out_vld && bus.out_rdy) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_item = sb_q.pop_front();
                    check("sb_data", 32'(bus.out_data),   32'(exp_item.data));
                    check("sb_sel",  32'(bus.sel_onehot), 32'(exp_item.sel));
                end
            end
        end
    end

    initial begin
        logic [NS-1:0] rdy;
        logic [NS-1:0] acc;
        logic [NS-1:0] pend;
        for (int i = 0; i < NS; i++) src_data[i] = '0;
        bus.req_vld  = '0;
        bus.req_data = '0;
        bus.out_rdy  = 1'b0;

        // Reset with random inputs, then idle after release.
        apply_reset(1'b1, 0);
        for (int n = 0; n < 4; n++) step('0, 1'($urandom), rdy, acc);

        // Full contention: strict rotation 0..4.
        for (int i = 0; i < NS; i++) src_data[i] = 16'h1000 + 16'(i);
        for (int n = 0; n < 10; n++) begin
            step(5'b11111, 1'b1, rdy, acc);
            check("rr_rdy", 32'(rdy), 32'(1 << (n % NS)));
            if (n > 0) check("rr_sel", 32'(bus.sel_onehot), 32'(1 << ((n - 1) % NS)));
        end

        // Sparse rotation with pointer wrap.
        step(5'b00100, 1'b1, rdy, acc);
        check("full_cnt", 32'(bus.gnt_cnt), 32'd10);
        check("sparse_src2", 32'(rdy), 32'b00100);
        step(5'b10010, 1'b1, rdy, acc);
        check("sparse_src4", 32'(rdy), 32'b10000);
        step(5'b10010, 1'b1, rdy, acc);
        check("sparse_src1", 32'(rdy), 32'b00010);

        // Backpressure while holding source 3.
        step(5'b01000, 1'b1, rdy, acc);
        check("bp_load3", 32'(rdy), 32'b01000);
        for (int n = 0; n < 4; n++) begin
            step(5'b11111, 1'b0, rdy, acc);
            check("bp_rdy",  32'(rdy),          32'd0);
            check("bp_data", 32'(bus.out_data), 32'h1003);
            check("bp_cnt",  32'(bus.gnt_cnt),  32'd14);
        end
        step(5'b11111, 1'b1, rdy, acc);
        check("bp_release", 32'(rdy), 32'b10000);

        // Drain to empty keeps the last data.
        step('0, 1'b1, rdy, acc);
        check("drain_data_in", 32'(bus.out_data), 32'h1004);
        step('0, 1'b1, rdy, acc);
        check("drain_vld",  32'(bus.out_vld),    32'd0);
        check("drain_sel",  32'(bus.sel_onehot), 32'd0);
        check("drain_data", 32'(bus.out_data),   32'h1004);

        // Random traffic; a requester holds valid and data until accepted.
        pend = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NS; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i]     = 1'b1;
                    src_data[i] = 16'($urandom);
                end
            end
            step(pend, ($urandom_range(0, 9) < 7), rdy, acc);
            pend &= ~acc;
        end

        // Counter wrap.
        apply_reset(1'b1, 0);
        for (int i = 0; i < NS; i++) src_data[i] = 16'h1000 + 16'(i);
        for (int n = 0; n < 65534 + 3; n++) step(5'b11111, 1'b1, rdy, acc);
        step('0, 1'b0, rdy, acc);
        check("cnt_wrap", 32'(bus.gnt_cnt), 32'h0001);

        // Reset while the output register is full, then source 0 wins first.
        apply_reset(1'b0, 3);
        step(5'b11111, 1'b1, rdy, acc);
        check("post_rst_src0", 32'(rdy), 32'b00001);
        step('0, 1'b1, rdy, acc);
        step('0, 1'b1, rdy, acc);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
